// File: rtl/rx_sched_pkg.sv
// rx_stream_sched shared types: FSM states, channel modes, sample geometry.
// Optional statistics counters are enabled with RX_SCHED_STATS_EN.
package rx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND
  } state_t;

  localparam logic [1:0] MODE_09   = 2'b00;
  localparam logic [1:0] MODE_24   = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  localparam int BYTES_PER_SAMPLE = 4;

  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

endpackage

// File: rtl/rx_stream_sched_if.sv
// FIFO read ports and SMI byte path of rx_stream_sched.
// RX_SCHED_STATS_EN adds the statistics counter outputs.
interface rx_stream_sched_if;

  logic        o_fifo_09_pull;
  logic [31:0] i_fifo_09_data;
  logic        i_fifo_09_empty;
  logic        o_fifo_24_pull;
  logic [31:0] i_fifo_24_data;
  logic        i_fifo_24_empty;
  logic        i_byte_req;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        o_chan_tag;
  logic        o_underrun;
`ifdef RX_SCHED_STATS_EN
  logic [15:0] o_underrun_count;
  logic [15:0] o_sample_count;

  modport master (
    output o_fifo_09_pull, o_fifo_24_pull,
    input  i_fifo_09_data, i_fifo_09_empty,
    input  i_fifo_24_data, i_fifo_24_empty,
    input  i_byte_req,
    output o_byte, o_byte_valid, o_chan_tag, o_underrun,
    output o_underrun_count, o_sample_count
  );

  modport slave (
    input  o_fifo_09_pull, o_fifo_24_pull,
    output i_fifo_09_data, i_fifo_09_empty,
    output i_fifo_24_data, i_fifo_24_empty,
    output i_byte_req,
    input  o_byte, o_byte_valid, o_chan_tag, o_underrun,
    input  o_underrun_count, o_sample_count
  );
`else
  modport master (
    output o_fifo_09_pull, o_fifo_24_pull,
    input  i_fifo_09_data, i_fifo_09_empty,
    input  i_fifo_24_data, i_fifo_24_empty,
    input  i_byte_req,
    output o_byte, o_byte_valid, o_chan_tag, o_underrun
  );

  modport slave (
    input  o_fifo_09_pull, o_fifo_24_pull,
    output i_fifo_09_data, i_fifo_09_empty,
    output i_fifo_24_data, i_fifo_24_empty,
    output i_byte_req,
    input  o_byte, o_byte_valid, o_chan_tag, o_underrun
  );
`endif

endinterface

// File: rtl/rx_sched_serializer.sv
// Holds one captured sample and hands it out MSB-first, one byte per request.
// Also flags requests that arrive while no byte is on offer.
module rx_sched_serializer
  import rx_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        tag,
  input  logic        req,
  output logic [7:0]  dout,
  output logic        valid,
  output logic        chan_tag,
  output logic        underrun,
  output logic        last
);

  logic [31:0] sreg;
  logic [1:0]  idx;

  assign dout = sreg[31:24];
  assign last = valid & req
              & (idx == 2'(BYTES_PER_SAMPLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      chan_tag <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= req & ~valid;
      if (load) begin
        sreg     <= data;
        idx      <= '0;
        valid    <= 1'b1;
        chan_tag <= tag;
      end else if (valid & req) begin
        sreg <= {sreg[23:0], 8'h00};
        idx  <= idx + 2'd1;
        if (last) valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_stream_sched.sv
// Drains the 0.9/2.4 GHz RX sample FIFOs into the SMI byte path.
// Define RX_SCHED_STATS_EN for underrun and sample counters.
module rx_stream_sched
  import rx_sched_pkg::*;
#(
  parameter int BURST_LEN = 1
) (
  input  logic       i_sys_clk,
  input  logic       i_reset,
  input  logic [1:0] i_mode,
  rx_stream_sched_if.master bus
);

  state_t      state, state_n;
  logic        pref, sel;
  logic [7:0]  burst;
  logic        pick, pick_ok, pull;
  logic        load, last, underrun;
  logic        e09, e24;
  logic [31:0] cap_data;

  assign e09 = bus.i_fifo_09_empty;
  assign e24 = bus.i_fifo_24_empty;

  // Round robin falls back to the other channel rather than stalling.
  always_comb begin
    pick    = CH_09;
    pick_ok = 1'b0;
    unique case (1'b1)
      (i_mode == MODE_09): begin
        pick    = CH_09;
        pick_ok = ~e09;
      end
      (i_mode == MODE_24): begin
        pick    = CH_24;
        pick_ok = ~e24;
      end
      (i_mode == MODE_RR): begin
        if (pref == CH_09 ? ~e09 : ~e24) begin
          pick    = pref;
          pick_ok = 1'b1;
        end else if (pref == CH_09 ? ~e24 : ~e09) begin
          pick    = ~pref;
          pick_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pull = (state == S_IDLE) & pick_ok & ~i_reset;

  assign bus.o_fifo_09_pull = pull & (pick == CH_09);
  assign bus.o_fifo_24_pull = pull & (pick == CH_24);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      S_IDLE:    if (pull) state_n = S_CAPTURE;
      S_CAPTURE: begin
        load    = 1'b1;
        state_n = S_SEND;
      end
      S_SEND:    if (last) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      sel   <= CH_09;
      pref  <= CH_09;
      burst <= '0;
    end else begin
      state <= state_n;
      if (pull) begin
        sel <= pick;
        if (i_mode == MODE_RR) begin
          if (pick != pref || burst == 8'(BURST_LEN - 1)) begin
            pref  <= ~pref;
            burst <= '0;
          end else begin
            burst <= burst + 8'd1;
          end
        end
      end
    end
  end

  assign cap_data = (sel == CH_24) ? bus.i_fifo_24_data
                                   : bus.i_fifo_09_data;

  rx_sched_serializer u_ser (
    .clk      (i_sys_clk),
    .rst      (i_reset),
    .load     (load),
    .data     (cap_data),
    .tag      (sel),
    .req      (bus.i_byte_req),
    .dout     (bus.o_byte),
    .valid    (bus.o_byte_valid),
    .chan_tag (bus.o_chan_tag),
    .underrun (underrun),
    .last     (last)
  );

  assign bus.o_underrun = underrun;

`ifdef RX_SCHED_STATS_EN
  logic [15:0] urun_cnt, samp_cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      urun_cnt <= '0;
      samp_cnt <= '0;
    end else begin
      if (underrun && urun_cnt != 16'hFFFF)
        urun_cnt <= urun_cnt + 16'd1;
      if (load)
        samp_cnt <= samp_cnt + 16'd1;
    end
  end

  assign bus.o_underrun_count = urun_cnt;
  assign bus.o_sample_count   = samp_cnt;
`endif

endmodule
